// File: rtl/usb_serial_fifo_if.sv
// usb_serial_fifo_if: byte stream handshake between a producer/consumer (master) and the FIFO (slave).
// Carries both the write and read handshakes plus the occupancy and drop counters.
interface usb_serial_fifo_if #(
    parameter int DEPTH = 64,
    parameter int LW    = $clog2(DEPTH) + 1
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic [7:0]    drop_count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, level, drop_count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, level, drop_count
    );
endinterface

// File: rtl/usb_serial_fifo.sv
// usb_serial_fifo: byte-wide first-word-fall-through FIFO (RAM of DEPTH-1 bytes plus a head register).
// Define USB_SERIAL_FIFO_DROP_EN to never stall the writer and count discarded bytes instead.
module usb_serial_fifo #(
    parameter int DEPTH = 64,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input logic              wb_clk_i,
    input logic              wb_reset_i,
    input logic              flush,
    usb_serial_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    ram [DEPTH-1];
    logic [PW-1:0] wp, rp;
    logic [LW-1:0] level;
    logic [7:0]    head;
    logic          head_v;
    logic [7:0]    drops;
    logic          full, ram_busy, wr, rd, ram_we, ram_re, head_ld;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 2)) ? '0 : p + 1'b1;
    endfunction

    assign full     = level == LW'(DEPTH);
    assign ram_busy = level > LW'(1);
    assign wr       = bus.in_valid && !full && !flush;
    assign rd       = head_v && bus.out_ready && !flush;
    assign ram_re   = rd && ram_busy;
    // A write lands in RAM unless the head is (or is about to become) empty.
    assign ram_we   = wr && ((head_v && !rd) || ram_busy);
    assign head_ld  = wr && !ram_we;

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            wp     <= '0;
            rp     <= '0;
            level  <= '0;
            head   <= 8'h00;
            head_v <= 1'b0;
        end else if (flush) begin
            wp     <= '0;
            rp     <= '0;
            level  <= '0;
            head_v <= 1'b0;
        end else begin
            if (ram_we) wp <= nxt(wp);
            if (ram_re) rp <= nxt(rp);
            head   <= ram_re ? ram[rp] : head_ld ? bus.in_data : head;
            head_v <= (head_v && !rd) || ram_re || head_ld;
            level  <= (wr && !rd) ? level + 1'b1 : (rd && !wr) ? level - 1'b1 : level;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (ram_we) ram[wp] <= bus.in_data;
    end

`ifdef USB_SERIAL_FIFO_DROP_EN
    assign bus.in_ready = 1'b1;

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) drops <= 8'h00;
        else if (!flush && bus.in_valid && full && drops != 8'hff) drops <= drops + 1'b1;
    end
`else
    assign bus.in_ready = !full;
    assign drops        = 8'h00;
`endif

    assign bus.out_data   = head;
    assign bus.out_valid  = head_v;
    assign bus.level      = level;
    assign bus.drop_count = drops;
endmodule

// File: tb/tb_usb_serial_fifo.sv
// tb_usb_serial_fifo: table vectors plus a queue scoreboard for usb_serial_fifo.
// Exercises fill/drain, streaming across pointer wrap, flush, async reset and random traffic.
module tb_usb_serial_fifo;
    localparam int DEPTH = 64;
`ifdef USB_SERIAL_FIFO_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk, rst, flush;
    int   errs, checks, mdrop;
    logic [7:0] q[$];

    usb_serial_fifo_if #(.DEPTH(DEPTH)) bus ();
    usb_serial_fifo #(.DEPTH(DEPTH)) dut (.wb_clk_i(clk), .wb_reset_i(rst), .flush(flush), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        int         lvl;
        logic       ov;
        logic [7:0] od;
    } vec_t;
    vec_t tbl [10];

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void check_state();
        chk("level", int'(bus.level), q.size());
        chk("out_valid", int'(bus.out_valid), int'(q.size() > 0));
        if (q.size() > 0) chk("out_data", int'(bus.out_data), int'(q[0]));
        chk("in_ready", int'(bus.in_ready), DROP ? 1 : int'(q.size() != DEPTH));
        chk("drop_count", int'(bus.drop_count), mdrop);
    endfunction

    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        logic acc, rdm;
        flush        = fl;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.out_ready = ordy;
        acc = iv && (q.size() < DEPTH);
        rdm = ordy && (q.size() > 0);
        if (DROP && !fl && iv && q.size() == DEPTH && mdrop < 255) mdrop++;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            if (rdm) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_level", int'(bus.level), 0);
    endtask

    initial begin
        errs = 0; checks = 0; mdrop = 0;
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b1, 8'h41};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b1, 8'h41};
        tbl[2] = '{1'b1, 8'h43, 1'b1, 1'b0, 2, 1'b1, 8'h42};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h43};
        tbl[4] = '{1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b1, 8'h44};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h44};
        tbl[6] = '{1'b1, 8'h50, 1'b0, 1'b0, 1, 1'b1, 8'h50};
        tbl[7] = '{1'b1, 8'h51, 1'b0, 1'b0, 2, 1'b1, 8'h50};
        tbl[8] = '{1'b1, 8'h55, 1'b1, 1'b1, 0, 1'b0, 8'h50};
        tbl[9] = '{1'b1, 8'h66, 1'b0, 1'b0, 1, 1'b1, 8'h66};

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        #12;
        chk("rst_level", int'(bus.level), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_drop", int'(bus.drop_count), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_level", i), int'(bus.level), tbl[i].lvl);
            chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), int'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("tbl%0d_data", i), int'(bus.out_data), int'(tbl[i].od));
        end
        drain();

        // Fill to full, push against full, then read out in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_level", int'(bus.level), DEPTH);
        chk("full_ready", int'(bus.in_ready), DROP ? 1 : 0);
        for (int i = 0; i < (DROP ? 300 : 1); i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("over_level", int'(bus.level), DEPTH);
        chk("over_drop", int'(bus.drop_count), DROP ? 255 : 0);
        chk("over_head", int'(bus.out_data), 0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("rdfull_level", int'(bus.level), DEPTH - 1);
        drain();

        for (int i = 0; i < 200; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        chk("stream1_level", int'(bus.level), 1);
        drain();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b1, 8'(i * 3), 1'b1, 1'b0);
        chk("stream5_level", int'(bus.level), 5);
        drain();

        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        chk("flush_level", int'(bus.level), 0);
        chk("flush_valid", int'(bus.out_valid), 0);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        chk("flush_next", int'(bus.out_data), 8'h66);
        drain();

        // Asynchronous reset between edges at level 37.
        for (int i = 0; i < 37; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_level", int'(bus.level), 0);
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_data", int'(bus.out_data), 0);
        chk("arst_ready", int'(bus.in_ready), 1);
        chk("arst_drop", int'(bus.drop_count), 0);
        q.delete();
        mdrop = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h12, 1'b0, 1'b0);
        chk("arst_first", int'(bus.out_data), 8'h12);
        drain();

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 60) == 0));
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/usb_serial_fifo.md
# usb_serial_fifo

Byte-wide first-word-fall-through FIFO that buffers serial traffic between the Wishbone USB-serial register block and the USB serial core's byte pipelines. One instance sits on the transmit path: Wishbone THR writes feed it, and it drains into the core's `uart_in` handshake. A second instance sits on the receive path: the core's `uart_out` stream feeds it, and RHR reads drain it. It supplies fill level and flush so firmware can poll occupancy instead of spinning on single-byte ready flags.

## Interface
- `DEPTH`, 64: storage in bytes; power of two, ≥ 4; the head output register is included in this count.
- `LW`, `$clog2(DEPTH)+1`: width of `level`.
- `wb_clk_i`  in  1  sole clock.
- `wb_reset_i`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  synchronous clear of all contents.
- `in_data`  in  8  upstream byte.
- `in_valid`  in  1  upstream byte present.
- `in_ready`  out  1  FIFO accepts `in_data` this cycle.
- `out_data`  out  8  registered head byte.
- `out_valid`  out  1  head byte present.
- `out_ready`  in  1  downstream consumes the head this cycle.
- `level`  out  LW  bytes currently held, 0..DEPTH.
- `drop_count`  out  8  saturating count of discarded writes (see Configuration).

## Operation
- Write transfer: `in_valid && in_ready` at a clock edge. Read transfer: `out_valid && out_ready` at a clock edge.
- Storage: RAM of DEPTH-1 bytes plus a head register driving `out_data`.
- Write and read pointers wrap modulo DEPTH-1 through explicit compare-and-reset logic, not by bit truncation.
- Head refill on a read transfer:
  - RAM non-empty: the next byte moves RAM → head.
  - RAM empty and a simultaneous write: the written byte loads the head directly.
  - RAM empty, no write: `out_valid` falls.
- Write into an empty FIFO bypasses the RAM and loads the head directly.
- `level` is registered:
  - +1 on a write-only edge.
  - −1 on a read-only edge.
  - Unchanged on a simultaneous read and write.
- `in_ready = (level != DEPTH)`, decoded from registered state. A read in the same cycle does not open a slot, so there is no full pass-through.
- Simultaneous read and write at `level == 1`: the head takes the new byte, `out_valid` stays 1, `level` stays 1.
- `flush` has priority over both ports. On that edge:
  - `level` and pointers go to 0 and `out_valid` to 0.
  - Any write or read presented in the same cycle is ignored.
  - `out_data` and `drop_count` are unchanged.
- Reset, asynchronous and applicable mid-transfer: `level=0`, `out_valid=0`, `out_data=8'h00`, `drop_count=0`, pointers 0. `in_ready` reads 1 after reset.
- Byte order is strictly preserved; no byte is duplicated or lost except as described in Configuration.

## Timing
- Latency from a write into an empty FIFO at edge N:
  - `out_valid=1` and `out_data=byte` in the cycle after edge N.
  - `level=1` in the same cycle.
- Throughput: one write and one read per cycle sustained at any level from 1 to DEPTH-1.
- `out_data` holds stable while `out_valid && !out_ready`.
- `in_ready` and `out_valid` have no combinational path from `in_valid`, `out_ready` or `flush`.
- After the edge where `level` reaches DEPTH, `in_ready` is 0 until the edge following the first read.

## Configuration
- `USB_SERIAL_FIFO_DROP_EN` defined:
  - `in_ready` is tied to 1.
  - A write arriving while `level == DEPTH` is discarded, and `drop_count` increments, saturating at 255.
  - A simultaneous read at full still frees no slot for that write; the byte is dropped.
  - This mode is intended for the receive path, where the USB side cannot be stalled.
- `USB_SERIAL_FIFO_DROP_EN` undefined: backpressure behaviour as in Operation, and `drop_count` is constant 8'h00.

## Test plan
- Reset, then write 0x41 at edge N with `out_ready=0` → `out_valid=1`, `out_data=0x41` and `level=1` after edge N; `in_ready=1`.
- Write 0x00..0x3F back-to-back with `DEPTH=64` and `out_ready=0` → `level=64` and `in_ready=0`. Then read 64 times → bytes 0x00..0x3F in order, `level=0`, `out_valid=0`.
- Hold `in_valid` and `out_ready` high with an incrementing stream for 200 cycles starting empty → `level` stays at 1, and the output matches the input delayed by one cycle, including across pointer wrap.
- Fill to 10 bytes, assert `flush` together with `in_valid` (0x55) and `out_ready` → next cycle `level=0`, `out_valid=0`, 0x55 not stored. The following write of 0x66 appears as the head.
- Assert `wb_reset_i` asynchronously, between edges, at `level=37` → outputs reach their reset values immediately without a clock edge. After release, a write of 0x12 is the first byte read.
- With `USB_SERIAL_FIFO_DROP_EN`: fill to 64, then write 300 further bytes → `drop_count=255`, `in_ready=1` throughout, and the 64 stored bytes read back unchanged. Without the macro, `drop_count=0` and the 65th write stalls.
